// File: rtl/note_sequencer.sv
// Melody sequencer: walks a pattern RAM of (frequency_step, duration) entries and
// drives one oscillator's frequency_step plus a mute gate, timed in sound-strobe ticks.
module note_sequencer #(
  parameter int DEPTH_LOG2 = 5,
  parameter int TICK_DIV   = 512,
  parameter int GAP_TICKS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  strobe,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop_en,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [23:0]           wr_data,
  output logic [15:0]           frequency_step,
  output logic                  gate,
  output logic                  busy,
  output logic [DEPTH_LOG2-1:0] step_index,
  output logic                  done
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PW-1:0]         PRE_LAST   = PW'(TICK_DIV - 1);
  localparam logic [7:0]            GAP        = 8'(GAP_TICKS);
  localparam logic [DEPTH_LOG2-1:0] LAST_INDEX = DEPTH_LOG2'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EVAL,
    PLAY,
    DONE
  } state_t;

  state_t      state;
  logic [23:0] mem [DEPTH];
  logic [23:0] entry;
  logic [PW-1:0] prescaler;
  logic [7:0]  remaining;
  logic [7:0]  note_dur;

  logic [15:0] entry_freq;
  logic [7:0]  entry_dur;
  logic        tick;
  logic [7:0]  remaining_next;

  assign entry_freq     = entry[23:8];
  assign entry_dur      = entry[7:0];
  assign tick           = strobe && (prescaler == PRE_LAST);
  assign remaining_next = remaining - 8'd1;

  // Pattern RAM keeps its contents across reset, so it lives outside the reset domain.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      frequency_step <= '0;
      gate           <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      step_index     <= '0;
      prescaler      <= '0;
      remaining      <= '0;
      note_dur       <= '0;
      entry          <= '0;
    end else begin
      done <= 1'b0;
      if (stop && state != IDLE) begin
        state          <= IDLE;
        gate           <= 1'b0;
        frequency_step <= '0;
        busy           <= 1'b0;
        step_index     <= '0;
        prescaler      <= '0;
        remaining      <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state      <= LOAD;
              step_index <= '0;
              busy       <= 1'b1;
            end
          end

          LOAD: begin
            entry <= mem[step_index];
            state <= EVAL;
          end

          EVAL: begin
            if (entry_dur != 8'd0) begin
              frequency_step <= entry_freq;
              gate           <= (entry_freq != 16'd0);
              remaining      <= entry_dur;
              note_dur       <= entry_dur;
              prescaler      <= '0;
              state          <= PLAY;
            end else if (loop_en && step_index != '0) begin
              step_index <= '0;
              state      <= LOAD;
            end else begin
              // A marker at entry 0 never loops, otherwise playback would spin in zero time.
              state          <= DONE;
              done           <= 1'b1;
              gate           <= 1'b0;
              frequency_step <= '0;
            end
          end

          PLAY: begin
            if (strobe) begin
              if (tick) begin
                prescaler <= '0;
                remaining <= remaining_next;
                // frequency_step is left alone through the gap so the oscillator phase carries on.
                if (remaining_next <= GAP && note_dur > GAP) begin
                  gate <= 1'b0;
                end
                if (remaining == 8'd1) begin
                  if (step_index != LAST_INDEX) begin
                    step_index <= step_index + 1'b1;
                    state      <= LOAD;
                  end else if (loop_en) begin
                    step_index <= '0;
                    state      <= LOAD;
                  end else begin
                    state          <= DONE;
                    done           <= 1'b1;
                    gate           <= 1'b0;
                    frequency_step <= '0;
                  end
                end
              end else begin
                prescaler <= prescaler + PW'(1);
              end
            end
          end

          DONE: begin
            state      <= IDLE;
            busy       <= 1'b0;
            step_index <= '0;
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: small RAM, TICK_DIV=4, one strobe every 8 clocks.
// Gate activity is tallied per entry in strobes so expectations read directly as durations.
module tb_note_sequencer;

  localparam int DL = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          strobe;
  logic          start;
  logic          stop;
  logic          loop_en;
  logic          wr_en;
  logic [DL-1:0] wr_addr;
  logic [23:0]   wr_data;
  logic [15:0]   frequency_step;
  logic          gate;
  logic          busy;
  logic [DL-1:0] step_index;
  logic          done;

  int tests    = 0;
  int failures = 0;
  int phase    = 0;

  int          hi_cnt[8];
  int          lo_cnt[8];
  logic [15:0] freq_seen[8];
  int          done_cnt;
  int          trace[$];
  int          last_idx;

  note_sequencer #(
    .DEPTH_LOG2(DL),
    .TICK_DIV  (4),
    .GAP_TICKS (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .strobe        (strobe),
    .start         (start),
    .stop          (stop),
    .loop_en       (loop_en),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .frequency_step(frequency_step),
    .gate          (gate),
    .busy          (busy),
    .step_index    (step_index),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int trace_at(input int i);
    return (i < trace.size()) ? trace[i] : -1;
  endfunction

  task automatic clear_record();
    for (int i = 0; i < 8; i++) begin
      hi_cnt[i]    = 0;
      lo_cnt[i]    = 0;
      freq_seen[i] = '0;
    end
    done_cnt = 0;
    trace.delete();
    last_idx = -1;
  endtask

  // One clock: tally the strobe about to be consumed, then sample 1 time unit after the edge.
  task automatic cycle();
    if (busy === 1'b1 && strobe) begin
      if (gate) hi_cnt[step_index]++;
      else      lo_cnt[step_index]++;
      freq_seen[step_index] = frequency_step;
    end
    @(posedge clk);
    #1;
    phase  = (phase + 1) % 8;
    strobe = (phase == 7);
    if (done === 1'b1) done_cnt++;
    if (busy === 1'b1 && int'(step_index) != last_idx) begin
      trace.push_back(int'(step_index));
      last_idx = int'(step_index);
    end
    if (busy !== 1'b1) last_idx = -1;
  endtask

  // Start on the clock right after a strobe so no strobe lands in LOAD/EVAL.
  task automatic start_pattern();
    do cycle(); while (phase != 0);
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic run_until_idle(input int budget, input string tag);
    int n = 0;
    while (busy === 1'b1 && n < budget) begin
      cycle();
      n++;
    end
    check({tag, " reaches idle"}, busy, 0);
  endtask

  task automatic write_entry(input int addr, input int freq, input int dur);
    wr_en   = 1'b1;
    wr_addr = addr[DL-1:0];
    wr_data = {freq[15:0], dur[7:0]};
    cycle();
    wr_en   = 1'b0;
  endtask

  task automatic load_basic();
    write_entry(0, 352, 3);
    write_entry(1, 443, 2);
    write_entry(2, 0, 0);
  endtask

  initial begin
    int n;
    bit found;

    rst     = 1'b0;
    strobe  = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    loop_en = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    clear_record();

    #2 rst = 1'b1;
    #1;
    check("reset freq", frequency_step, 0);
    check("reset gate", gate, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset index", step_index, 0);
    cycle();
    cycle();
    rst = 1'b0;

    // Basic pattern
    load_basic();
    clear_record();
    start_pattern();
    run_until_idle(400, "s1");
    check("s1 e0 gate high strobes", hi_cnt[0], 8);
    check("s1 e0 gate low strobes", lo_cnt[0], 4);
    check("s1 e0 freq", freq_seen[0], 352);
    check("s1 e1 gate high strobes", hi_cnt[1], 4);
    check("s1 e1 gate low strobes", lo_cnt[1], 4);
    check("s1 e1 freq", freq_seen[1], 443);
    check("s1 marker strobes", hi_cnt[2] + lo_cnt[2], 0);
    check("s1 done pulses", done_cnt, 1);
    check("s1 end freq", frequency_step, 0);
    check("s1 end gate", gate, 0);
    check("s1 trace length", trace.size(), 3);

    // Rest then a note no longer than the gap
    write_entry(0, 0, 2);
    write_entry(1, 500, 1);
    write_entry(2, 0, 0);
    clear_record();
    start_pattern();
    run_until_idle(400, "s2");
    check("s2 rest gate low strobes", lo_cnt[0], 8);
    check("s2 rest gate high strobes", hi_cnt[0], 0);
    check("s2 rest freq", freq_seen[0], 0);
    check("s2 short gate high strobes", hi_cnt[1], 4);
    check("s2 short gate low strobes", lo_cnt[1], 0);
    check("s2 short freq", freq_seen[1], 500);
    check("s2 done pulses", done_cnt, 1);

    // Looping, then letting the pattern finish
    load_basic();
    loop_en = 1'b1;
    clear_record();
    start_pattern();
    n = 0;
    while (trace.size() < 5 && n < 600) begin
      cycle();
      n++;
    end
    check("s3 trace reached", trace.size(), 5);
    check("s3 trace 2", trace_at(2), 2);
    check("s3 trace 3 wraps", trace_at(3), 0);
    check("s3 trace 4", trace_at(4), 1);
    check("s3 no done while looping", done_cnt, 0);
    loop_en = 1'b0;
    run_until_idle(400, "s3");
    check("s3 final trace length", trace.size(), 6);
    check("s3 final entry", trace_at(5), 2);
    check("s3 done pulses", done_cnt, 1);

    // Marker at entry 0 with looping enabled
    write_entry(0, 0, 0);
    loop_en = 1'b1;
    clear_record();
    start = 1'b1;
    found = 0;
    for (int k = 0; k < 3 && !found; k++) begin
      cycle();
      start = 1'b0;
      if (done === 1'b1) found = 1;
    end
    start = 1'b0;
    check("s3 marker0 done within 3 clks", found, 1);
    run_until_idle(20, "s3 marker0");
    check("s3 marker0 single done", done_cnt, 1);
    loop_en = 1'b0;

    // Full table without a marker
    for (int i = 0; i < 8; i++) write_entry(i, 1000 + i * 16, 1);
    clear_record();
    start_pattern();
    run_until_idle(600, "s4");
    check("s4 trace length", trace.size(), 8);
    check("s4 last entry", trace_at(7), 7);
    check("s4 e0 gate high strobes", hi_cnt[0], 4);
    check("s4 e7 gate high strobes", hi_cnt[7], 4);
    check("s4 e7 gate low strobes", lo_cnt[7], 0);
    check("s4 e7 freq", freq_seen[7], 1112);
    check("s4 done pulses", done_cnt, 1);

    loop_en = 1'b1;
    clear_record();
    start_pattern();
    n = 0;
    while (trace.size() < 10 && n < 800) begin
      cycle();
      n++;
    end
    check("s4 loop trace 7", trace_at(7), 7);
    check("s4 loop wraps to 0", trace_at(8), 0);
    check("s4 loop no done", done_cnt, 0);
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    check("s4 stop busy", busy, 0);
    loop_en = 1'b0;

    // Stop, stop with start, start while busy
    load_basic();
    clear_record();
    start_pattern();
    repeat (40) cycle();
    check("s5 gate mid-note", gate, 1);
    check("s5 freq mid-note", frequency_step, 352);
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    check("s5 stop gate", gate, 0);
    check("s5 stop freq", frequency_step, 0);
    check("s5 stop busy", busy, 0);
    check("s5 stop index", step_index, 0);
    repeat (3) cycle();
    check("s5 stop no done", done_cnt, 0);

    clear_record();
    start_pattern();
    repeat (40) cycle();
    stop  = 1'b1;
    start = 1'b1;
    cycle();
    stop  = 1'b0;
    start = 1'b0;
    check("s5 stop+start busy", busy, 0);
    repeat (4) cycle();
    check("s5 stop+start stays idle", busy, 0);
    check("s5 stop+start no done", done_cnt, 0);

    clear_record();
    start_pattern();
    n = 0;
    while (step_index !== 3'd1 && n < 200) begin
      cycle();
      n++;
    end
    check("s5 reached entry 1", step_index, 1);
    start = 1'b1;
    repeat (5) cycle();
    start = 1'b0;
    run_until_idle(400, "s5 busy start");
    check("s5 busy start trace length", trace.size(), 3);
    check("s5 busy start e1 high", hi_cnt[1], 4);
    check("s5 busy start e1 low", lo_cnt[1], 4);
    check("s5 busy start done", done_cnt, 1);

    // Asynchronous reset mid-note, RAM retained
    clear_record();
    start_pattern();
    repeat (40) cycle();
    #2 rst = 1'b1;
    #1;
    check("s6 async rst gate", gate, 0);
    check("s6 async rst freq", frequency_step, 0);
    check("s6 async rst busy", busy, 0);
    check("s6 async rst index", step_index, 0);
    #3 rst = 1'b0;
    clear_record();
    start_pattern();
    run_until_idle(400, "s6 replay");
    check("s6 replay e0 high", hi_cnt[0], 8);
    check("s6 replay e0 freq", freq_seen[0], 352);
    check("s6 replay e1 freq", freq_seen[1], 443);
    check("s6 replay done", done_cnt, 1);

    // Writes during playback
    clear_record();
    start_pattern();
    repeat (20) cycle();
    write_entry(1, 600, 2);
    write_entry(0, 777, 3);
    run_until_idle(400, "s6 write");
    check("s6 playing note unchanged", freq_seen[0], 352);
    check("s6 playing note length", hi_cnt[0] + lo_cnt[0], 12);
    check("s6 rewritten entry freq", freq_seen[1], 600);
    check("s6 rewritten entry high", hi_cnt[1], 4);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
